// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding plus the bit-counter width calculation used by the top.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for a WIDTH-bit operand; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
// Purely combinational; used as the serial cell and reusable elsewhere.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first) behind a start/done handshake.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a two's-complement overflow output.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             a_sign;
    logic             b_sign;
`endif

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == LAST_BIT);

    assign ready  = (state == IDLE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands shift right one bit per RUN cycle; each difference bit enters at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res    <= '0;
            cnt    <= '0;
            borrow <= bin;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res    <= {cell_d, res[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            borrow <= cell_bout;
            if (last) begin
                diff <= {cell_d, res[WIDTH-1:1]};
                bout <= cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                // The final cell output is the result sign bit.
                ovf  <= (a_sign != b_sign) && (cell_d != a_sign);
`endif
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor, LSB first: diff = a - b - bin. It uses one full-subtractor cell and a borrow flip-flop, and is the subtract-direction counterpart of the team's full-adder arithmetic. It sits behind a start/done handshake for area-constrained datapaths that can afford WIDTH cycles per operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), localparam; width of the bit counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  registered difference.
- bout  output  1  registered borrow-out.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, ready=1, busy=0, done=0.
  - diff=0, bout=0, borrow FF=0, counter=0, shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start=1:
  - load a and b into shift registers and bin into the borrow FF.
  - clear counter; ready drops in the next cycle.
- RUN, one bit per clock:
  - cell inputs: x=a_sh[0], y=b_sh[0], z=borrow.
  - d = x^y^z; bnext = (~x&y) | (~x&z) | (y&z).
  - d shifts into the MSB of the result register; a_sh and b_sh shift right; borrow <= bnext; counter++.
  - after the edge that processes bit WIDTH-1 (counter==WIDTH-1): go to DONE; diff takes the full result; bout takes the final borrow.
- DONE: done=1 for exactly one cycle; always returns to IDLE on the next edge.
- Latency: start accepted at edge t -> done high during the cycle after edge t+WIDTH. Issue interval is WIDTH+2 cycles.
- diff and bout are updated only on the RUN->DONE edge and hold until the next completion. A new start does not clear them.
- start in RUN or DONE is ignored, not queued; operands may change freely then.
- Arithmetic (unsigned): diff = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin.
- Boundaries:
  - a=b, bin=0 -> 0, bout=0.
  - a=0, b=0, bin=1 -> all ones, bout=1.
  - a=b=all ones, bin=1 -> all ones, bout=1.
- Reset mid-RUN aborts immediately to reset values; no done pulse is produced.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - extra output port ovf (1 bit), reset 0, updated with diff.
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]): two's-complement overflow of a-b-bin.
  - the sign bits of a and b are captured at start.
- Undefined: no ovf port and no associated registers.

Decomposition:
- Package serial_subtractor_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - localparam function for CNT_W.
- Sub-module full_subtractor (combinational):
  - inputs x, y, bin; outputs d, bout.
  - instantiated once for the serial cell; reusable elsewhere as the subtractor cell.

Test Plan (all WIDTH=8):
- a=0x05, b=0x03, bin=0, start for 1 cycle -> done pulses 9 cycles after the accepting edge's cycle; diff=0x02, bout=0; ready re-rises the cycle after done.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Busy-ignore: a=0x80, b=0x01 accepted; at RUN cycle 3, assert start with a=0xFF, b=0x00 -> exactly one done, diff=0x7F, bout=0; with SERIAL_SUBTRACTOR_OVF_EN, ovf=1.
- Reset mid-run: after a=0x10, b=0x01 is accepted, drive rst_n=0 at RUN cycle 4 -> same cycle shows ready=1, busy=0, done=0, diff=0x00, bout=0; no done pulse after rst_n rises.
- Back-to-back: hold start=1 continuously with a=0x0A, b=0x0A, bin=0, then a=0xFF, b=0xFF, bin=1 -> one operation per WIDTH+2 cycles; results 0x00/bout=0, then 0xFF/bout=1.
- Random regression: 1000 random a, b, bin vectors checked against the golden model (a-b-bin) mod 256 and borrow; with the macro, also check ovf.
